// File: rtl/npu_matadd_pkg.sv
// Shared types and sizes for the matrix-add scheduler and its round-robin arbiter.
// Operands are 4x4 bytes; results are 4x4 16-bit words, both packed row-major.
package npu_matadd_pkg;

    localparam int MAT_DIM      = 4;
    localparam int ELEM_W       = 8;
    localparam int RES_W        = 16;
    localparam int MAT_BITS_IN  = MAT_DIM * MAT_DIM * ELEM_W;
    localparam int MAT_BITS_OUT = MAT_DIM * MAT_DIM * RES_W;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
// Returns both a one-hot grant and the encoded winner index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    // Scan from the farthest offset back to ptr so the nearest request wins last.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt                           = '0;
                gnt[(int'(ptr) + k) % N]      = 1'b1;
                idx                           = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/matadd_sched.sv
// Shares one 4x4 matrix-add engine among NUM_REQ requesters with round-robin arbitration.
// Tolerates a sticky engine done flag by ignoring it until ENG_LATENCY cycles have elapsed.
module matadd_sched
    import npu_matadd_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ENG_LATENCY = 22,
    parameter int TIMEOUT     = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*MAT_BITS_IN-1:0]   req_a,
    input  logic [NUM_REQ*MAT_BITS_IN-1:0]   req_b,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic                             rsp_err,
    output logic [MAT_BITS_OUT-1:0]          rsp_c,
    output logic                             busy,
    output logic                             eng_start,
    output logic [MAT_BITS_IN-1:0]           eng_a,
    output logic [MAT_BITS_IN-1:0]           eng_b,
    input  logic [MAT_BITS_OUT-1:0]          eng_c,
    input  logic                             eng_done
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    sched_state_t        state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       win;
    logic [CW-1:0]       cnt;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IW-1:0]       arb_idx;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign busy = (state != IDLE);

    always_comb begin
        eng_a = '0;
        eng_b = '0;
        if (|gnt) begin
            eng_a = req_a[int'(win) * MAT_BITS_IN +: MAT_BITS_IN];
            eng_b = req_b[int'(win) * MAT_BITS_IN +: MAT_BITS_IN];
        end
    end

    // rsp_err doubles as the job's error flag: set on timeout, cleared on leaving RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_c     <= '0;
            eng_start <= 1'b0;
            ptr       <= '0;
            win       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        win       <= arb_idx;
                        gnt       <= arb_gnt;
                        eng_start <= 1'b1;
                        cnt       <= '0;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    eng_start <= 1'b0;
                    cnt       <= cnt + 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (cnt >= CW'(ENG_LATENCY) && eng_done) begin
                        rsp_c     <= eng_c;
                        rsp_valid <= NUM_REQ'(1) << win;
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        rsp_valid <= NUM_REQ'(1) << win;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    rsp_err   <= 1'b0;
                    gnt       <= '0;
                    ptr       <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matadd_sched.sv
// Directed bench for matadd_sched with a behavioural engine model and a response scoreboard.
module tb_matadd_sched;

    localparam int N   = 4;
    localparam int LAT = 22;
    localparam int TO  = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*128-1:0] req_a;
    logic [N*128-1:0] req_b;
    logic [N-1:0]     gnt;
    logic [N-1:0]     rsp_valid;
    logic             rsp_err;
    logic [255:0]     rsp_c;
    logic             busy;
    logic             eng_start;
    logic [127:0]     eng_a;
    logic [127:0]     eng_b;
    logic [255:0]     eng_c;
    logic             eng_done;

    matadd_sched #(
        .NUM_REQ    (N),
        .ENG_LATENCY(LAT),
        .TIMEOUT    (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_a    (req_a),
        .req_b    (req_b),
        .gnt      (gnt),
        .rsp_valid(rsp_valid),
        .rsp_err  (rsp_err),
        .rsp_c    (rsp_c),
        .busy     (busy),
        .eng_start(eng_start),
        .eng_a    (eng_a),
        .eng_b    (eng_b),
        .eng_c    (eng_c),
        .eng_done (eng_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int           idx;
        bit           err;
        logic [255:0] c;
    } exp_t;
    exp_t         sb[$];
    logic [255:0] last_c = '0;

    // Engine model: done is sticky and rises LAT cycles after start-accept.
    logic [127:0] ea_l, eb_l;
    logic         done_r;
    int           ecnt;
    bit           eng_never = 1'b0;

    function automatic logic [255:0] add_mats(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] r;
        for (int k = 0; k < 16; k++) r[k*16 +: 16] = 16'(a[k*8 +: 8]) + 16'(b[k*8 +: 8]);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r <= 1'b0;
            ecnt   <= 0;
            eng_c  <= '0;
            ea_l   <= '0;
            eb_l   <= '0;
        end else if (eng_start) begin
            ecnt <= 1;
            ea_l <= eng_a;
            eb_l <= eng_b;
        end else if (ecnt != 0) begin
            if (ecnt == LAT - 1) begin
                done_r <= 1'b1;
                eng_c  <= add_mats(ea_l, eb_l);
                ecnt   <= 0;
            end else begin
                ecnt <= ecnt + 1;
            end
        end
    end

    assign eng_done = eng_never ? 1'b0 : done_r;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
        checks++;
        assert (obs === want) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    function automatic logic [127:0] fill8(input int v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(v);
        return r;
    endfunction

    function automatic logic [255:0] fill16(input int v);
        logic [255:0] r;
        for (int k = 0; k < 16; k++) r[k*16 +: 16] = 16'(v);
        return r;
    endfunction

    task automatic set_ops(input int idx, input int av, input int bv);
        req_a[idx*128 +: 128] = fill8(av);
        req_b[idx*128 +: 128] = fill8(bv);
    endtask

    task automatic push_exp(input int idx, input bit err, input int sum);
        exp_t e;
        e.idx = idx;
        e.err = err;
        if (!err) last_c = fill16(sum);
        e.c = last_c;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_idle_timeout", 256'(busy), 256'(0));
    endtask

    task automatic wait_rsp(output int at);
        int n = 0;
        at = -1;
        @(negedge clk);
        while (rsp_valid === '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_rsp_timeout", 256'(rsp_valid), 256'(1));
        else at = cyc;
    endtask

    task automatic run_job(input string tag, input int idx, input int av, input int bv,
                           input bit err, input int lat);
        int t0, t1;
        wait_idle();
        set_ops(idx, av, bv);
        push_exp(idx, err, av + bv);
        req      = '0;
        req[idx] = 1'b1;
        @(negedge clk);
        chk({tag, "_start"}, 256'(eng_start), 256'(1));
        chk({tag, "_gnt"}, 256'(gnt), 256'(req));
        chk({tag, "_eng_a"}, 256'(eng_a), 256'(fill8(av)));
        t0 = cyc;
        wait_rsp(t1);
        chk({tag, "_lat"}, 256'(t1 - t0), 256'(lat));
        req = '0;
    endtask

    logic [N-1:0] prev_rv = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (gnt != '0) chk("gnt_onehot", 256'($onehot(gnt)), 256'(1));
            if (prev_rv != '0) chk("rsp_pulse", 256'(rsp_valid), 256'(0));
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", 256'(rsp_valid), 256'(0));
                end else begin
                    e = sb.pop_front();
                    chk("sb_rsp_valid", 256'(rsp_valid), 256'(N'(1) << e.idx));
                    chk("sb_rsp_err", 256'(rsp_err), 256'(e.err));
                    if (!e.err) chk("sb_rsp_c", rsp_c, e.c);
                    else chk("sb_rsp_c_kept", rsp_c, e.c);
                end
            end
        end
        prev_rv = rsp_valid;
    end

    initial begin
        int t0, t1;
        rst_n = 1'b0;
        req   = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 256'(gnt), 256'(0));
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("rst_rsp_err", 256'(rsp_err), 256'(0));
        chk("rst_rsp_c", rsp_c, 256'(0));
        chk("rst_eng_start", 256'(eng_start), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_eng_a", 256'(eng_a), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single job, then a second job that must ignore the stale done flag.
        run_job("single", 0, 3, 5, 1'b0, LAT + 1);
        run_job("stale", 1, 200, 255, 1'b0, LAT + 1);

        // Timeout keeps the previous rsp_c; the next job reports no error.
        eng_never = 1'b1;
        run_job("timeout", 2, 1, 1, 1'b1, TO + 1);
        eng_never = 1'b0;
        run_job("after_to", 3, 7, 9, 1'b0, LAT + 1);

        // Fairness with all requests held: order 0,1,2,3,0.
        wait_idle();
        for (int i = 0; i < N; i++) set_ops(i, 10 * i + 7, 3 * i + 100);
        for (int i = 0; i < 5; i++) push_exp(i % N, 1'b0, 10 * (i % N) + 7 + 3 * (i % N) + 100);
        req = '1;
        for (int i = 0; i < 5; i++) wait_rsp(t1);
        req = '0;

        // Request drop after grant still completes, with no re-grant.
        wait_idle();
        set_ops(2, 17, 34);
        push_exp(2, 1'b0, 51);
        req = 4'b0100;
        @(negedge clk);
        chk("drop_gnt", 256'(gnt), 256'(4'b0100));
        t0 = cyc;
        repeat (2) @(negedge clk);
        req[2] = 1'b0;
        wait_rsp(t1);
        chk("drop_lat", 256'(t1 - t0), 256'(LAT + 1));
        repeat (5) @(negedge clk);
        chk("drop_no_regrant", 256'(gnt), 256'(0));
        chk("drop_idle", 256'(busy), 256'(0));

        // Reset during WAIT aborts silently and restores pointer 0.
        set_ops(3, 9, 9);
        req = 4'b1000;
        @(negedge clk);
        chk("rstw_start", 256'(eng_start), 256'(1));
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstw_gnt", 256'(gnt), 256'(0));
        chk("rstw_eng_start", 256'(eng_start), 256'(0));
        chk("rstw_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("rstw_busy", 256'(busy), 256'(0));
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_ops(1, 40, 60);
        push_exp(1, 1'b0, 100);
        req = 4'b1010;
        @(negedge clk);
        chk("rstw_regrant", 256'(gnt), 256'(4'b0010));
        t0 = cyc;
        wait_rsp(t1);
        chk("rstw_lat", 256'(t1 - t0), 256'(LAT + 1));
        req = '0;

        repeat (5) @(negedge clk);
        chk("sb_drained", 256'(sb.size()), 256'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/matadd_sched.md
Name: matadd_sched

Overview:
- Round-robin scheduler that shares one 4x4 matrix-addition engine (8-bit operands, 16-bit results) among NUM_REQ requesters.
- Arbitrates requests, muxes the winner's operands onto the engine, and pulses the engine start.
- Detects completion despite the engine's sticky done flag, then returns the result to the winner.
- Sits between the NPU command front-end ports and the single matrix-add datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ENG_LATENCY, 22, minimum cycles from start-accept to valid engine done
TIMEOUT, 64, WAIT cycles before a job is aborted with error (must exceed ENG_LATENCY)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester job request; level, held until its rsp_valid
req_a  in  NUM_REQ*128  per-requester operand A, 16 bytes, row-major, element [0][0] in LSBs
req_b  in  NUM_REQ*128  per-requester operand B, same packing
gnt  out  NUM_REQ  one-hot grant, held from arbitration until the response cycle
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the winner
rsp_err  out  1  qualifies rsp_valid: 1 = timeout abort
rsp_c  out  256  result, 16 x 16-bit row-major, broadcast to all requesters
busy  out  1  high in any state other than IDLE
eng_start  out  1  engine start pulse
eng_a  out  128  muxed operand A to engine
eng_b  out  128  muxed operand B to engine
eng_c  in  256  engine result
eng_done  in  1  engine done; level, may remain high from the previous job

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values: state IDLE, gnt 0, rsp_valid 0, rsp_err 0, rsp_c 0, eng_start 0, rr pointer 0, cycle counter 0.
- eng_a/eng_b are combinational from the latched winner index; they are 0 when no grant is held.
- States:
  - IDLE: if req nonzero, select the first asserted bit at or after the rr pointer (wrapping). Latch the index, set gnt, go to LAUNCH.
  - LAUNCH: eng_start=1 for exactly one cycle, counter cleared to 0. Go to WAIT.
  - WAIT: counter += 1 each cycle, saturating.
    - If counter >= ENG_LATENCY and eng_done=1, capture eng_c into rsp_c and go to RESP.
    - Else if counter == TIMEOUT, set the error flag and go to RESP. rsp_c keeps its previous value.
  - RESP: rsp_valid[winner]=1 and rsp_err=error flag for one cycle. Clear gnt. rr pointer = (winner+1) mod NUM_REQ. Clear the error flag. Go to IDLE.
- eng_done is ignored before ENG_LATENCY, because the sticky flag from a previous job must not complete a new one.
- Latency: req sampled in IDLE at cycle t gives eng_start at t+1.
  - With eng_done high by counter==ENG_LATENCY: rsp_valid at t+ENG_LATENCY+2.
  - Back-to-back jobs are separated by one IDLE cycle.
- Requests are sampled only in IDLE.
  - Deasserting req after grant does not abort; the job completes and rsp_valid still pulses.
  - A requester may reassert req in its own RESP cycle. It then loses priority to others that are already pending.
- Simultaneous requests are resolved purely by the rr pointer. No requester waits more than NUM_REQ-1 jobs.
- Reset mid-job returns to IDLE immediately with no rsp_valid. The engine is reset by the same rst_n.
- rsp_c width rule: passed through unmodified (16-bit per element). The engine's sums of two 8-bit values never exceed 510.

Decomposition:
- Package npu_matadd_pkg holds:
  - MAT_DIM=4, ELEM_W=8, RES_W=16
  - MAT_BITS_IN=128, MAT_BITS_OUT=256
  - state enum sched_state_t {IDLE, LAUNCH, WAIT, RESP}
- Sub-module rr_arbiter (parameter N), combinational, with two outputs:
  - one-hot grant from req and pointer
  - encoded index
- matadd_sched owns the FSM, counter, pointer update and operand mux.

Test Plan:
- Single job: req=0001, all A elements 3, all B elements 5, engine model with done at 22 → eng_start at t+1, rsp_valid=0001 at t+24, rsp_err=0, every rsp_c element 8.
- Stale done: eng_done held high from the prior job → no completion before counter reaches 22. The second job's rsp_c is its own sum (A=200, B=255 gives 455), not the previous result.
- Fairness: req=1111 held continuously → grant order 0,1,2,3,0. Each rsp_valid is one cycle and strictly one-hot; gnt is never multi-hot.
- Timeout: engine never raises done → rsp_valid to the winner at t+TIMEOUT+2 with rsp_err=1. The next job has rsp_err=0.
- Request drop: req[2] deasserted two cycles after grant → job completes, rsp_valid[2] pulses, and there is no re-grant of 2 unless req reasserts.
- Reset in WAIT: rst_n low at counter=10 → gnt, eng_start, rsp_valid and busy all go to 0 immediately. The next req=0010 is granted with pointer 0 (index 1 wins).
